intr_controller: RTL and testbench

//  Interrupt request side of the core's INTR/Inject_Int handshake. Feeds Control_unit.

---
 rtl/intr_controller.sv | 127 ++++++++++++
 tb/tb_intr_controller.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/intr_controller.sv
// -----------------------------------------------------------------------------
// intr_controller
//   Request side of the core's INTR / Inject_Int handshake, feeding the
//   Control_unit. External request pins are synchronised, rising edges are
//   latched as pending, and the unmasked pending sources are arbitrated with
//   fixed priority (lowest index wins). INTR is held until the Control_unit
//   acknowledges with Inject_Int. No new request is raised until the
//   handler's RTI retires (rti_done).
//
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   irq_in      asynchronous request pins, rising-edge triggered
//   irq_mask    1 = source masked (still latched as pending, not arbitrated)
//   Inject_Int  1-cycle ack: phantom interrupt instruction injected
//   rti_done    1-cycle pulse: RTI retired
//   INTR        interrupt request to Control_unit
//   intr_vec    index of the granted source, stable while INTR=1
//   in_service  handler active
//   pending     latched pending bits (status)
// -----------------------------------------------------------------------------
module intr_controller #(
  parameter int NUM_SRC     = 4,
  parameter int SYNC_STAGES = 2,
  parameter int VEC_W       = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] irq_in,
  input  logic [NUM_SRC-1:0] irq_mask,
  input  logic               Inject_Int,
  input  logic               rti_done,
  output logic               INTR,
  output logic [VEC_W-1:0]   intr_vec,
  output logic               in_service,
  output logic [NUM_SRC-1:0] pending
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t state, state_next;

  // Element [0] is the first synchroniser flop, [SYNC_STAGES-1] the last.
  logic [SYNC_STAGES-1:0][NUM_SRC-1:0] sync_q;
  logic [NUM_SRC-1:0]                  sync_last_d;
  logic [NUM_SRC-1:0]                  edge_det;
  logic [NUM_SRC-1:0]                  eligible;
  logic [NUM_SRC-1:0]                  clr;
  logic [VEC_W-1:0]                    vec_next;

  // Lowest set index of req; returns 0 when req is empty (caller guards).
  function automatic logic [VEC_W-1:0] prio_enc(input logic [NUM_SRC-1:0] req);
    logic [VEC_W-1:0] idx;
    idx = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req[i]) idx = VEC_W'(i);
    end
    return idx;
  endfunction

  // Synchroniser chain plus one extra flop for rising-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q      <= '0;
      sync_last_d <= '0;
    end else begin
      sync_q      <= {sync_q[SYNC_STAGES-2:0], irq_in};
      sync_last_d <= sync_q[SYNC_STAGES-1];
    end
  end

  assign edge_det = sync_q[SYNC_STAGES-1] & ~sync_last_d;
  assign eligible = pending & ~irq_mask;

  // A fresh edge on the bit being cleared wins, so the new request survives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
    end else begin
      pending <= edge_det | (pending & ~clr);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      intr_vec <= '0;
    end else begin
      state    <= state_next;
      intr_vec <= vec_next;
    end
  end

  // Strobes arriving in the wrong state fall through to the defaults and
  // leave everything unchanged.
  always_comb begin
    state_next = state;
    vec_next   = intr_vec;
    clr        = '0;
    case (state)
      IDLE: begin
        if (eligible != '0) begin
          state_next = REQ;
          vec_next   = prio_enc(eligible);
        end
      end
      REQ: begin
        if (Inject_Int) begin
          state_next = SERVICE;
          clr        = NUM_SRC'(1) << intr_vec;
        end
      end
      SERVICE: begin
        if (rti_done) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign INTR       = (state == REQ);
  assign in_service = (state == SERVICE);

endmodule

// File: tb/tb_intr_controller.sv
module tb_intr_controller;

  localparam int N  = 4;
  localparam int S  = 2;
  localparam int VW = 2;

  logic          clk;
  logic          rst;
  logic [N-1:0]  irq_in;
  logic [N-1:0]  irq_mask;
  logic          Inject_Int;
  logic          rti_done;
  logic          INTR;
  logic [VW-1:0] intr_vec;
  logic          in_service;
  logic [N-1:0]  pending;

  intr_controller #(.NUM_SRC(N), .SYNC_STAGES(S), .VEC_W(VW)) dut (
    .clk        (clk),
    .rst        (rst),
    .irq_in     (irq_in),
    .irq_mask   (irq_mask),
    .Inject_Int (Inject_Int),
    .rti_done   (rti_done),
    .INTR       (INTR),
    .intr_vec   (intr_vec),
    .in_service (in_service),
    .pending    (pending)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic          intr;
    logic [VW-1:0] vec;
    logic          insvc;
    logic [N-1:0]  pend;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: pin samples kept as a history queue, handler phase as
  // an integer (0 idle, 1 requesting, 2 servicing), granted index g.
  logic [N-1:0] samp_q[$];
  logic [N-1:0] m_pend;
  int           m_phase;
  int           m_g;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic int lowest(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic model_reset();
    samp_q.delete();
    for (int i = 0; i <= S; i++) samp_q.push_back('0);
    m_pend  = '0;
    m_phase = 0;
    m_g     = 0;
  endtask

  // Applies the rules for one clock edge using the inputs present at it.
  task automatic model_step();
    logic [N-1:0] rise;
    logic [N-1:0] clr;
    logic [N-1:0] elig;
    // samp_q[0] was sampled S+1 edges ago, samp_q[1] S edges ago.
    rise = samp_q[1] & ~samp_q[0];
    samp_q.delete(0);
    samp_q.push_back(irq_in);
    clr  = '0;
    elig = m_pend & ~irq_mask;
    if (m_phase == 0) begin
      if (elig != '0) begin
        m_phase = 1;
        m_g     = lowest(elig);
      end
    end else if (m_phase == 1) begin
      if (Inject_Int) begin
        m_phase  = 2;
        clr[m_g] = 1'b1;
      end
    end else begin
      if (rti_done) m_phase = 0;
    end
    m_pend = rise | (m_pend & ~clr);
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    if (rst) model_reset();
    else model_step();
    e.intr  = (m_phase == 1);
    e.vec   = VW'(m_g);
    e.insvc = (m_phase == 2);
    e.pend  = m_pend;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic cyc(input logic [N-1:0] i, input logic [N-1:0] m,
                     input logic a, input logic r);
    irq_in     = i;
    irq_mask   = m;
    Inject_Int = a;
    rti_done   = r;
    tick();
  endtask

  // Monitor: compares every registered DUT output against the queued
  // expectation for the edge just past.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("mon_intr",    32'(INTR),       32'(e.intr));
        chk("mon_vec",     32'(intr_vec),   32'(e.vec));
        chk("mon_insvc",   32'(in_service), 32'(e.insvc));
        chk("mon_pending", 32'(pending),    32'(e.pend));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [N-1:0] ir;
    logic [N-1:0] mk;
    logic a;
    logic r;

    rst = 1'b1; irq_in = '0; irq_mask = '0; Inject_Int = 1'b0; rti_done = 1'b0;
    model_reset();
    tick();
    tick();
    rst = 1'b0;
    chk("reset_intr",    32'(INTR),       32'd0);
    chk("reset_pending", 32'(pending),    32'd0);
    cyc('0, '0, 0, 0);

    // Single source: latency and acknowledge.
    cyc(4'b0100, '0, 0, 0);
    n = 0;
    while (!INTR && n < 10) begin
      cyc('0, '0, 0, 0);
      n++;
    end
    chk("t1_latency", 32'(n), 32'(S + 1));
    chk("t1_vec", 32'(intr_vec), 32'd2);
    cyc('0, '0, 1, 0);
    chk("t1_ack_intr",  32'(INTR),       32'd0);
    chk("t1_ack_insvc", 32'(in_service), 32'd1);
    chk("t1_ack_pend2", 32'(pending[2]), 32'd0);
    cyc('0, '0, 0, 1);
    cyc('0, '0, 0, 0);

    // Priority: sources 3 and 1 together.
    cyc(4'b1010, '0, 0, 0);
    n = 0;
    while (!INTR && n < 10) begin
      cyc('0, '0, 0, 0);
      n++;
    end
    chk("t2_first_vec", 32'(intr_vec), 32'd1);
    cyc('0, '0, 1, 0);
    cyc('0, '0, 0, 1);
    chk("t2_gap_intr", 32'(INTR), 32'd0);
    cyc('0, '0, 0, 0);
    chk("t2_second_intr", 32'(INTR), 32'd1);
    chk("t2_second_vec",  32'(intr_vec), 32'd3);
    cyc('0, '0, 1, 0);
    cyc('0, '0, 0, 1);
    cyc('0, '0, 0, 0);

    // Mask holds off arbitration but not latching.
    cyc(4'b0001, 4'b0001, 0, 0);
    for (int i = 0; i < 4; i++) cyc('0, 4'b0001, 0, 0);
    chk("t3_pending", 32'(pending), 32'h1);
    chk("t3_intr",    32'(INTR),    32'd0);
    cyc('0, '0, 0, 0);
    chk("t3_unmask_intr", 32'(INTR),     32'd1);
    chk("t3_unmask_vec",  32'(intr_vec), 32'd0);

    // No nesting while in service.
    cyc('0, '0, 1, 0);
    cyc(4'b0001, '0, 0, 0);
    for (int i = 0; i < 4; i++) cyc('0, '0, 0, 0);
    chk("t4_intr_held", 32'(INTR),       32'd0);
    chk("t4_pend0",     32'(pending[0]), 32'd1);
    cyc('0, '0, 0, 1);
    chk("t4_gap", 32'(INTR), 32'd0);
    cyc('0, '0, 0, 0);
    chk("t4_reassert", 32'(INTR), 32'd1);

    // Collision: new edge on granted source lands with Inject_Int.
    cyc(4'b0001, '0, 0, 0);
    cyc('0, '0, 0, 0);
    cyc('0, '0, 1, 0);
    chk("t5_insvc", 32'(in_service), 32'd1);
    chk("t5_pend0", 32'(pending[0]), 32'd1);
    cyc('0, '0, 0, 1);
    cyc('0, '0, 0, 0);
    cyc('0, '0, 1, 0);
    cyc('0, '0, 0, 1);
    cyc('0, '0, 0, 0);

    // Asynchronous reset while requesting, pin then held high.
    cyc(4'b1000, '0, 0, 0);
    n = 0;
    while (!INTR && n < 10) begin
      cyc(4'b1000, '0, 0, 0);
      n++;
    end
    chk("t6_pre_intr", 32'(INTR), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("t6_async_intr",  32'(INTR),       32'd0);
    chk("t6_async_pend",  32'(pending),    32'd0);
    chk("t6_async_insvc", 32'(in_service), 32'd0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) cyc(4'b1000, '0, 0, 0);
    cyc(4'b1000, '0, 1, 0);
    cyc(4'b1000, '0, 0, 1);
    for (int i = 0; i < 6; i++) cyc(4'b1000, '0, 0, 0);
    chk("t6_single_edge_pend", 32'(pending), 32'd0);
    chk("t6_single_edge_intr", 32'(INTR),    32'd0);

    // Randomised traffic including spurious strobes.
    ir = 4'b1000;
    mk = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < N; b++) if ($urandom_range(0, 7) == 0) ir[b] = ~ir[b];
      if ($urandom_range(0, 31) == 0) mk = N'($urandom);
      a = (m_phase == 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 15) == 0);
      r = (m_phase == 2) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 15) == 0);
      cyc(ir, mk, a, r);
    end

    #2;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
